// File: rtl/serial_adder_pkg.sv
// ---------------------------------------------------------------------------
// serial_adder_pkg
//   Shared definitions for the bit-serial adder:
//     - state_t : controller states (IDLE, RUN, DONE)
//     - fa_sum  : full-adder sum bit
//     - fa_maj  : full-adder carry (majority of the three inputs)
// ---------------------------------------------------------------------------
package serial_adder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic logic fa_sum(input logic x, input logic y, input logic ci);
    return x ^ y ^ ci;
  endfunction

  function automatic logic fa_maj(input logic x, input logic y, input logic ci);
    return (x & y) | (x & ci) | (y & ci);
  endfunction

endpackage

// File: rtl/shift_reg_piso.sv
// ---------------------------------------------------------------------------
// shift_reg_piso
//   Parallel-load, shift-right register that presents its LSB serially.
//   Zeros enter at the MSB. Load has priority over shift.
// Ports:
//   clk     : rising-edge clock
//   rst     : asynchronous active-high reset (clears contents)
//   i_load  : load i_din on the next edge
//   i_shift : shift right by one on the next edge
//   i_din   : parallel load data, W bits
//   o_lsb   : current bit 0 of the register
// ---------------------------------------------------------------------------
module shift_reg_piso #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic         i_shift,
  input  logic [W-1:0] i_din,
  output logic         o_lsb
);

  logic [W-1:0] r_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q <= '0;
    end else if (i_load) begin
      r_q <= i_din;
    end else if (i_shift) begin
      r_q <= {1'b0, r_q[W-1:1]};
    end
  end

  assign o_lsb = r_q[0];

endmodule

// File: rtl/serial_adder.sv
// ---------------------------------------------------------------------------
// serial_adder
//   Bit-serial N-bit two's-complement adder. Operands are captured on an
//   accepted start and fed LSB-first through one full-adder cell; the carry
//   lives in a one-bit flop between cycles. After N shifts the parallel sum,
//   unsigned carry-out and signed overflow are published with a one-cycle
//   done pulse. Outputs hold until the next result is published.
// Ports:
//   clk   : rising-edge clock
//   rst   : asynchronous active-high reset
//   start : request an addition (accepted in IDLE or DONE, ignored in RUN)
//   a, b  : N-bit operands, captured on the accepting edge
//   busy  : high while shifting
//   done  : one-cycle pulse, sum/cout/ovf valid
//   sum   : (a+b) mod 2^N
//   cout  : carry out of the MSB
//   ovf   : carry into MSB XOR carry out of MSB
// ---------------------------------------------------------------------------
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] sum,
  output logic         cout,
  output logic         ovf
);

  localparam int             CW   = $clog2(N) + 1;
  localparam logic [CW-1:0]  LAST = CW'(N - 1);

  state_t          r_state;
  logic            r_carry;
  logic [CW-1:0]   r_cnt;
  logic [N-1:0]    r_acc;
  logic [N-1:0]    r_sum;
  logic            r_cout;
  logic            r_ovf;
  logic            r_busy;
  logic            r_done;

  logic            w_a;
  logic            w_b;
  logic            w_s;
  logic            w_c;
  logic            w_load;
  logic            w_shift;
  logic            w_last;
  logic [N-1:0]    w_acc_next;

  // Operands may only be (re)loaded when not shifting, so a start during
  // RUN has no effect on the operation in flight.
  assign w_load  = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
  assign w_shift = (r_state == ST_RUN);
  assign w_last  = w_shift && (r_cnt == LAST);

  shift_reg_piso #(.W(N)) u_sr_a (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_load),
    .i_shift (w_shift),
    .i_din   (a),
    .o_lsb   (w_a)
  );

  shift_reg_piso #(.W(N)) u_sr_b (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_load),
    .i_shift (w_shift),
    .i_din   (b),
    .o_lsb   (w_b)
  );

  assign w_s = fa_sum(w_a, w_b, r_carry);
  assign w_c = fa_maj(w_a, w_b, r_carry);

  // Sum bits enter at the MSB and move right, so after N shifts bit 0 of
  // the result sits in bit 0 of the accumulator.
  assign w_acc_next = {w_s, r_acc[N-1:1]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_acc   <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          if (w_load) begin
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_acc   <= '0;
            r_busy  <= 1'b1;
            r_state <= ST_RUN;
          end
        end

        ST_RUN: begin
          r_acc   <= w_acc_next;
          r_carry <= w_c;
          r_cnt   <= r_cnt + CW'(1);
          if (w_last) begin
            // Publish the result on the final shift; r_carry still holds
            // the carry into the MSB at this point.
            r_sum   <= w_acc_next;
            r_cout  <= w_c;
            r_ovf   <= r_carry ^ w_c;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= ST_DONE;
          end
        end

        ST_DONE: begin
          r_done <= 1'b0;
          if (w_load) begin
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_acc   <= '0;
            r_busy  <= 1'b1;
            r_state <= ST_RUN;
          end else begin
            r_state <= ST_IDLE;
          end
        end

        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign sum  = r_sum;
  assign cout = r_cout;
  assign ovf  = r_ovf;

endmodule

// File: tb/tb_serial_adder.sv
module tb_serial_adder;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         busy;
  logic         done;
  logic [N-1:0] sum;
  logic         cout;
  logic         ovf;

  int checks   = 0;
  int failures = 0;

  serial_adder #(.N(N)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .ovf   (ovf)
  );

  always #5 clk = ~clk;

  // Reference: plain integer addition; returns {ovf, cout, sum}.
  function automatic logic [N+1:0] ref_add(input logic [N-1:0] x, input logic [N-1:0] y);
    logic [N:0]   full;
    logic [N-1:0] r;
    logic         v;
    full = {1'b0, x} + {1'b0, y};
    r    = full[N-1:0];
    v    = (x[N-1] == y[N-1]) && (r[N-1] != x[N-1]);
    return {v, full[N], r};
  endfunction

  // Drives one operation from IDLE and waits (bounded) for done.
  // lat = edges after the accepting edge until done is seen (-1 on timeout).
  task automatic run_op(input logic [N-1:0] ia, input logic [N-1:0] ib,
                        output int lat, output bit busy_ok);
    a = ia;
    b = ib;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = -1;
    busy_ok = (busy === 1'b1);
    for (int e = 1; e <= 30; e++) begin
      @(posedge clk); #1;
      if (done === 1'b1) begin
        lat = e;
        if (busy !== 1'b0) busy_ok = 0;
        break;
      end else if (busy !== 1'b1) begin
        busy_ok = 0;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({busy, done, ovf, cout, sum} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got busy=%b done=%b ovf=%b cout=%b sum=%h want all zero",
               busy, done, ovf, cout, sum);
    end
    // start together with reset: reset must win
    start = 1'b1; a = 8'h11; b = 8'h22;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_beats_start got busy=%b want 0", busy);
    end
    start = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_directed();
    logic [N-1:0] va [3] = '{8'h35, 8'hFF, 8'h7F};
    logic [N-1:0] vb [3] = '{8'h4A, 8'h01, 8'h01};
    logic [N+1:0] exp;
    int lat;
    bit bok;
    for (int i = 0; i < 3; i++) begin
      exp = ref_add(va[i], vb[i]);
      run_op(va[i], vb[i], lat, bok);
      checks++;
      if ({ovf, cout, sum} !== exp) begin
        failures++;
        $display("FAIL directed_%0d result got ovf=%b cout=%b sum=%h want ovf=%b cout=%b sum=%h",
                 i, ovf, cout, sum, exp[N+1], exp[N], exp[N-1:0]);
      end
      checks++;
      if (lat !== N) begin
        failures++;
        $display("FAIL directed_%0d latency got %0d edges after start edge want %0d", i, lat, N);
      end
      checks++;
      if (!bok) begin
        failures++;
        $display("FAIL directed_%0d busy_window got irregular busy want high only while shifting", i);
      end
      // done is a single-cycle pulse; result holds while idle even if inputs move
      a = 8'hC3; b = 8'h3C;
      @(posedge clk); #1;
      checks++;
      if (done !== 1'b0) begin
        failures++;
        $display("FAIL directed_%0d done_pulse got done=%b one cycle later want 0", i, done);
      end
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({ovf, cout, sum} !== exp) begin
        failures++;
        $display("FAIL directed_%0d hold got sum=%h want %h", i, sum, exp[N-1:0]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [N+1:0] exp;
    int cnt;
    exp = ref_add(8'h80, 8'h80);
    a = 8'h80; b = 8'h80; start = 1'b1;
    @(posedge clk); #1;
    cnt = -1;
    for (int e = 1; e <= 30; e++) begin
      @(posedge clk); #1;
      if (done === 1'b1) begin cnt = e; break; end
    end
    checks++;
    if (cnt !== N || {ovf, cout, sum} !== exp) begin
      failures++;
      $display("FAIL b2b_first got lat=%0d ovf=%b cout=%b sum=%h want lat=%0d ovf=%b cout=%b sum=%h",
               cnt, ovf, cout, sum, N, exp[N+1], exp[N], exp[N-1:0]);
    end
    // start still high during DONE: new operands load on the DONE edge
    a = 8'h01; b = 8'h02;
    exp = ref_add(8'h01, 8'h02);
    cnt = -1;
    for (int e = 1; e <= 30; e++) begin
      @(posedge clk); #1;
      if (e == 1) begin
        start = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
          failures++;
          $display("FAIL b2b_reload got busy=%b after DONE edge want 1", busy);
        end
      end
      if (done === 1'b1) begin cnt = e; break; end
    end
    checks++;
    if (cnt !== N + 1) begin
      failures++;
      $display("FAIL b2b_period got %0d edges want %0d", cnt, N + 1);
    end
    checks++;
    if ({ovf, cout, sum} !== exp) begin
      failures++;
      $display("FAIL b2b_second got ovf=%b cout=%b sum=%h want ovf=%b cout=%b sum=%h",
               ovf, cout, sum, exp[N+1], exp[N], exp[N-1:0]);
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_start_ignored();
    logic [N+1:0] exp;
    int lat;
    int extra;
    exp = ref_add(8'h10, 8'h20);
    a = 8'h10; b = 8'h20; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = -1;
    for (int e = 1; e <= 30; e++) begin
      @(posedge clk); #1;
      if (e == 3) begin
        a = 8'hAA; b = 8'h55; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (done === 1'b1) begin lat = e; break; end
    end
    checks++;
    if (lat !== N || {ovf, cout, sum} !== exp) begin
      failures++;
      $display("FAIL start_ignored got lat=%0d sum=%h cout=%b ovf=%b want lat=%0d sum=%h cout=%b ovf=%b",
               lat, sum, cout, ovf, N, exp[N-1:0], exp[N], exp[N+1]);
    end
    extra = 0;
    for (int e = 1; e <= 15; e++) begin
      @(posedge clk); #1;
      if (done === 1'b1 || busy === 1'b1) extra++;
    end
    checks++;
    if (extra !== 0) begin
      failures++;
      $display("FAIL start_not_queued got %0d busy/done cycles want 0", extra);
    end
  endtask

  task automatic test_reset_mid_run();
    logic [N+1:0] exp;
    int lat;
    int dcount;
    bit bok;
    a = 8'hFF; b = 8'hFF; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({busy, done, ovf, cout, sum} !== '0) begin
      failures++;
      $display("FAIL reset_async got busy=%b done=%b ovf=%b cout=%b sum=%h want all zero",
               busy, done, ovf, cout, sum);
    end
    @(negedge clk);
    rst = 1'b0;
    dcount = 0;
    for (int e = 1; e <= 15; e++) begin
      @(posedge clk); #1;
      if (done === 1'b1 || busy === 1'b1) dcount++;
    end
    checks++;
    if (dcount !== 0) begin
      failures++;
      $display("FAIL reset_abort got %0d busy/done cycles after abort want 0", dcount);
    end
    exp = ref_add(8'h02, 8'h03);
    run_op(8'h02, 8'h03, lat, bok);
    checks++;
    if (lat !== N || !bok || {ovf, cout, sum} !== exp) begin
      failures++;
      $display("FAIL after_reset got lat=%0d busy_ok=%0d sum=%h cout=%b ovf=%b want lat=%0d sum=%h cout=%b ovf=%b",
               lat, bok, sum, cout, ovf, N, exp[N-1:0], exp[N], exp[N+1]);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    logic [N-1:0] ra;
    logic [N-1:0] rb;
    logic [N+1:0] exp;
    int lat;
    bit bok;
    for (int i = 0; i < 25; i++) begin
      ra = N'($urandom);
      rb = N'($urandom);
      exp = ref_add(ra, rb);
      run_op(ra, rb, lat, bok);
      checks++;
      if (lat !== N || !bok || {ovf, cout, sum} !== exp) begin
        failures++;
        $display("FAIL random_%0d a=%h b=%h got lat=%0d busy_ok=%0d sum=%h cout=%b ovf=%b want lat=%0d sum=%h cout=%b ovf=%b",
                 i, ra, rb, lat, bok, sum, cout, ovf, N, exp[N-1:0], exp[N], exp[N+1]);
      end
      repeat ($urandom_range(1, 3)) @(posedge clk);
      #1;
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_start_ignored();
    test_reset_mid_run();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
